// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : Splits one 32-bit word request from the MEM stage into two
//               sequential 16-bit accesses on an external synchronous SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_DE_N
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W_LO  = 3'd1,
        S_W_HI  = 3'd2,
        S_R_LO  = 3'd3,
        S_R_HI  = 3'd4,
        S_R_CAP = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;

    logic [31:0] w_offset;
    logic        w_req;
    logic        w_ready;
    logic [17:0] w_sram_addr;
    logic        w_we_n;
    logic        w_drive;
    logic [15:0] w_dq_out;
    logic        w_unused_bits;

    assign w_offset      = address - BASE_ADDR;
    assign w_req         = wr_en | rd_en;
    // Byte offset bits and the bits above the SRAM range do not reach the bus.
    assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_word <= w_offset[18:2];
            end
            if (r_state == S_IDLE && wr_en) begin
                r_wdata <= write_data;
            end
            // The SRAM output register lags the address by one cycle.
            if (r_state == S_R_HI) begin
                r_read_data[15:0] <= SRAM_DQ;
            end
            if (r_state == S_R_CAP) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_sram_addr = '0;
        w_we_n      = 1'b1;
        w_drive     = 1'b0;
        w_dq_out    = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = ~w_req;
                if (wr_en) begin
                    w_next = S_W_LO;
                end else if (rd_en) begin
                    w_next = S_R_LO;
                end
            end
            S_W_LO: begin
                w_sram_addr = {r_word, 1'b0};
                w_we_n      = 1'b0;
                w_drive     = 1'b1;
                w_dq_out    = r_wdata[15:0];
                w_next      = S_W_HI;
            end
            S_W_HI: begin
                w_sram_addr = {r_word, 1'b1};
                w_we_n      = 1'b0;
                w_drive     = 1'b1;
                w_dq_out    = r_wdata[31:16];
                w_next      = S_DONE;
            end
            S_R_LO: begin
                w_sram_addr = {r_word, 1'b0};
                w_next      = S_R_HI;
            end
            S_R_HI: begin
                w_sram_addr = {r_word, 1'b1};
                w_next      = S_R_CAP;
            end
            S_R_CAP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
    assign SRAM_ADDR = w_sram_addr;
    assign SRAM_WE_N = w_we_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_DE_N = 1'b0;
    assign ready     = w_ready;
    assign read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module      : tb_sram_controller
// Description : Directed bench for sram_controller with a synchronous SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [17:0] sram_addr;
    wire  [15:0] sram_dq;
    wire         sram_ub_n;
    wire         sram_lb_n;
    wire         sram_we_n;
    wire         sram_ce_n;
    wire         sram_de_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];
    logic [15:0] mem_q;
    logic        probe;
    logic [17:0] we_addr [0:1];
    logic [15:0] we_dq   [0:1];

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_DE_N  (sram_de_n)
    );

    // SRAM model: registered read data; probe drives a fixed pattern to expose bus contention.
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
        mem_q <= mem[sram_addr[7:0]];
    end

    assign sram_dq = sram_we_n ? (probe ? 16'hA5C3 : mem_q) : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_access(output int lat, output int we_cnt);
        lat    = 0;
        we_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            if (!sram_we_n) begin
                if (we_cnt < 2) begin
                    we_addr[we_cnt] = sram_addr;
                    we_dq[we_cnt]   = sram_dq;
                end
                we_cnt++;
            end
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic also_rd);
        int          lat;
        int          wcnt;
        logic [31:0] off;
        off        = a - 32'd1024;
        wr_en      = 1'b1;
        rd_en      = also_rd;
        address    = a;
        write_data = d;
        #1;
        run_access(lat, wcnt);
        check("wr_latency", lat, 4);
        check("wr_we_cycles", wcnt, 2);
        check("wr_lo_addr", {14'd0, we_addr[0]}, {14'd0, off[18:2], 1'b0});
        check("wr_lo_data", {16'd0, we_dq[0]}, {16'd0, d[15:0]});
        check("wr_hi_addr", {14'd0, we_addr[1]}, {14'd0, off[18:2], 1'b1});
        check("wr_hi_data", {16'd0, we_dq[1]}, {16'd0, d[31:16]});
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input logic hold);
        int lat;
        int wcnt;
        rd_en   = 1'b1;
        address = a;
        #1;
        run_access(lat, wcnt);
        check("rd_latency", lat, 5);
        check("rd_no_drive", wcnt, 0);
        check("rd_data", read_data, exp);
        if (hold) begin
            @(posedge clk);
            #1;
            check("done_no_restart", {14'd0, sram_addr}, 32'd0);
        end
        rd_en = 1'b0;
        #1;
        check("idle_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        probe      = 1'b1;

        #2 rst = 1'b1;
        #1;
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_dq_released", {16'd0, sram_dq}, {16'd0, 16'hA5C3});
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("tied_pins", {28'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_de_n}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        probe = 1'b0;
        @(posedge clk);
        #1;

        do_write(32'd1024, 32'hDEADBEEF, 1'b0);
        check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
        do_read(32'd1024, 32'hDEADBEEF, 1'b0);

        do_write(32'd1028, 32'h12345678, 1'b1);
        check("mem2", {16'd0, mem[2]}, 32'h00005678);
        check("mem3", {16'd0, mem[3]}, 32'h00001234);
        check("prio_read_data_kept", read_data, 32'hDEADBEEF);

        do_write(32'd1032, 32'hCAFEF00D, 1'b0);
        do_read(32'd1032, 32'hCAFEF00D, 1'b1);

        rd_en   = 1'b1;
        address = 32'd1024;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rhi_addr", {14'd0, sram_addr}, 32'd1);
        #2;
        rd_en = 1'b0;
        probe = 1'b1;
        rst   = 1'b1;
        #1;
        check("mid_rst_read_data", read_data, 32'd0);
        check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_rst_dq_released", {16'd0, sram_dq}, {16'd0, 16'hA5C3});
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        probe = 1'b0;
        @(posedge clk);
        #1;
        do_read(32'd1024, 32'hDEADBEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
